// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared state encoding, default width and bit-reverse helper for the shift frame controller
package shift_ctrl_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH = 64;
  localparam int MAX_IW = $clog2(MAX_WIDTH);
  typedef enum logic [2:0] {IDLE, CLR, SHIFT, SETTLE, CAP, DONE} state_t;
  function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] v, input int w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++)
      if (i < w) r[MAX_IW'(i)] = v[MAX_IW'(w - 1 - i)];
    return r;
  endfunction
endpackage

// File: rtl/shift_bit_counter.sv
// shift_bit_counter: bit index counter, wraps to zero after WIDTH-1 and flags the last bit
module shift_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW = $clog2(WIDTH)
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          load,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);
  assign tc = cnt == CW'(WIDTH - 1);
  // load restarts the frame at bit 0; en steps one bit, never past WIDTH-1
  always_ff @(posedge clock or negedge clear)
    if (!clear) cnt <= '0;
    else if (load) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/shift_frame_controller.sv
// shift_frame_controller: serialises an accepted word into an external right-shift register and returns its captured output
module shift_frame_controller
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sr_clear,
  output logic             sr_shift,
  output logic             sr_a,
  input  logic [WIDTH-1:0] sr_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] order;
  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt;
  logic tc;
  // hold is stored in shift order, so bit i goes out on shift i and hold is also the expected register image
  assign order = LSB_FIRST ? in_data : WIDTH'(bit_reverse(MAX_WIDTH'(in_data), WIDTH));
  assign nxt = cnt + 1'b1;
  shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clock(clock),
    .clear(clear),
    .load(state == CLR),
    .en(state == SHIFT),
    .cnt(cnt),
    .tc(tc)
  );
  // frame sequencer with all handshake and shift-register controls registered
  always_ff @(posedge clock or negedge clear)
    if (!clear) begin
      state <= IDLE;
      hold <= '0;
      in_ready <= 1'b1;
      sr_clear <= 1'b0;
      sr_shift <= 1'b0;
      sr_a <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_err <= 1'b0;
      busy <= 1'b0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          hold <= order;
          in_ready <= 1'b0;
          busy <= 1'b1;
          sr_clear <= 1'b1;
          state <= CLR;
        end
        CLR: begin
          sr_clear <= 1'b0;
          sr_shift <= 1'b1;
          sr_a <= hold[0];
          state <= SHIFT;
        end
        SHIFT: if (tc) begin
          sr_shift <= 1'b0;
          sr_a <= 1'b0;
          state <= SETTLE;
        end else sr_a <= hold[nxt];
        SETTLE: state <= CAP;
        CAP: begin
          out_data <= sr_out;
          out_err <= sr_out != hold;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_shift_frame_controller.sv
// tb_shift_frame_controller: directed checks of both bit orders against a behavioural shift register
module tb_shift_frame_controller;
  logic clock = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic sel = 1'b0;
  logic drop = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready_a, sr_clear_a, sr_shift_a, sr_a_a, out_valid_a, out_err_a, busy_a;
  logic in_ready_b, sr_clear_b, sr_shift_b, sr_a_b, out_valid_b, out_err_b, busy_b;
  logic [7:0] out_data_a, out_data_b;
  logic [7:0] sr_out_a = '0;
  logic [7:0] sr_out_b = '0;
  int nsh_a = 0;
  int nsh_b = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic obs_in_ready, obs_sr_clear, obs_sr_shift, obs_sr_a, obs_out_valid, obs_out_err, obs_busy;
  logic [7:0] obs_out_data;
  always #5 clock = ~clock;
  shift_frame_controller #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_a (
    .clock(clock), .clear(clear), .in_valid(in_valid & ~sel), .in_ready(in_ready_a), .in_data(in_data),
    .sr_clear(sr_clear_a), .sr_shift(sr_shift_a), .sr_a(sr_a_a), .sr_out(sr_out_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_err(out_err_a), .busy(busy_a)
  );
  shift_frame_controller #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
    .clock(clock), .clear(clear), .in_valid(in_valid & sel), .in_ready(in_ready_b), .in_data(in_data),
    .sr_clear(sr_clear_b), .sr_shift(sr_shift_b), .sr_a(sr_a_b), .sr_out(sr_out_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_err(out_err_b), .busy(busy_b)
  );
  assign obs_in_ready = sel ? in_ready_b : in_ready_a;
  assign obs_sr_clear = sel ? sr_clear_b : sr_clear_a;
  assign obs_sr_shift = sel ? sr_shift_b : sr_shift_a;
  assign obs_sr_a = sel ? sr_a_b : sr_a_a;
  assign obs_out_valid = sel ? out_valid_b : out_valid_a;
  assign obs_out_err = sel ? out_err_b : out_err_a;
  assign obs_busy = sel ? busy_b : busy_a;
  assign obs_out_data = sel ? out_data_b : out_data_a;
  // right-shift register models; serial bit enters the MSB, drop skips the third shift of a frame
  always @(posedge clock) begin
    if (sr_clear_a) begin
      sr_out_a <= '0;
      nsh_a <= 0;
    end else if (sr_shift_a) begin
      nsh_a <= nsh_a + 1;
      if (!(drop && nsh_a == 2)) sr_out_a <= {sr_a_a, sr_out_a[7:1]};
    end
    if (sr_clear_b) begin
      sr_out_b <= '0;
      nsh_b <= 0;
    end else if (sr_shift_b) begin
      nsh_b <= nsh_b + 1;
      sr_out_b <= {sr_a_b, sr_out_b[7:1]};
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // one frame from the accept edge through the result handshake; entered just after a falling edge with the DUT idle
  task automatic frame(input string tag, input logic [7:0] d, input int stall, input logic [7:0] exp_bits,
                       input logic [7:0] exp_d, input logic exp_e);
    logic [7:0] bits;
    bits = '0;
    in_valid = 1'b1;
    in_data = d;
    out_ready = (stall == 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k == 1) begin
        in_valid = 1'b0;
        in_data = ~d;
      end
      if (k >= 2 && k <= 9) bits[k-2] = obs_sr_a;
      check({tag, " sr_clear"}, 32'(obs_sr_clear), 32'(k == 1));
      check({tag, " sr_shift"}, 32'(obs_sr_shift), 32'(k >= 2 && k <= 9));
      check({tag, " out_valid"}, 32'(obs_out_valid), 32'(k == 12));
      if (k == 5) check({tag, " busy"}, 32'(obs_busy), 32'd1);
    end
    check({tag, " sr_a bits"}, 32'(bits), 32'(exp_bits));
    check({tag, " out_data"}, 32'(obs_out_data), 32'(exp_d));
    check({tag, " out_err"}, 32'(obs_out_err), 32'(exp_e));
    check({tag, " in_ready busy"}, 32'(obs_in_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      check({tag, " stall valid"}, 32'(obs_out_valid), 32'd1);
      check({tag, " stall data"}, 32'(obs_out_data), 32'(exp_d));
      check({tag, " stall in_ready"}, 32'(obs_in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    check({tag, " post valid"}, 32'(obs_out_valid), 32'd0);
    check({tag, " post in_ready"}, 32'(obs_in_ready), 32'd1);
  endtask
  initial begin
    logic seen;
    repeat (3) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    check("rst in_ready", 32'(in_ready_a), 32'd1);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst out_valid", 32'(out_valid_a), 32'd0);
    check("rst sr_shift", 32'(sr_shift_a), 32'd0);
    check("rst sr_clear", 32'(sr_clear_a), 32'd0);
    check("rst in_ready_b", 32'(in_ready_b), 32'd1);
    frame("lsb_a5", 8'hA5, 0, 8'hA5, 8'hA5, 1'b0);
    frame("stall_a5", 8'hA5, 5, 8'hA5, 8'hA5, 1'b0);
    in_valid = 1'b1;
    in_data = 8'h5A;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (5) @(negedge clock);
    check("abort in shift", 32'(sr_shift_a), 32'd1);
    clear = 1'b0;
    #1;
    check("abort sr_shift", 32'(sr_shift_a), 32'd0);
    check("abort in_ready", 32'(in_ready_a), 32'd1);
    check("abort busy", 32'(busy_a), 32'd0);
    check("abort out_valid", 32'(out_valid_a), 32'd0);
    @(negedge clock);
    clear = 1'b1;
    seen = 1'b0;
    repeat (14) begin
      @(negedge clock);
      if (out_valid_a) seen = 1'b1;
    end
    check("abort no result", 32'(seen), 32'd0);
    frame("after_abort_3c", 8'h3C, 0, 8'h3C, 8'h3C, 1'b0);
    drop = 1'b1;
    frame("drop_ff", 8'hFF, 0, 8'hFF, 8'hFE, 1'b1);
    drop = 1'b0;
    sel = 1'b1;
    frame("msb_01", 8'h01, 0, 8'h80, 8'h80, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
